// File: rtl/conv_seq_ctrl.sv
// Sequencing controller for a 3x3 streaming convolution: tracks pixel position,
// flags full/partial windows, aligns output valid to the pipeline and frames the image.
module conv_seq_ctrl #(
    parameter int IMG_W    = 640,
    parameter int IMG_H    = 480,
    parameter int PIPE_LAT = 2
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iDVAL,
    input  logic        iFRAME_START,
    input  logic        iMODE,
    output logic        oLB_CLKEN,
    output logic        oVERTICAL,
    output logic        oWIN_VALID,
    output logic        oBORDER,
    output logic        oDVAL,
    output logic [10:0] oX,
    output logic [10:0] oY,
    output logic        oFRAME_DONE,
    output logic        oBUSY
);

    localparam int FW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
    localparam logic [10:0]   X_LAST     = 11'(IMG_W - 1);
    localparam logic [10:0]   Y_LAST     = 11'(IMG_H - 1);
    localparam logic [FW-1:0] FLUSH_LAST = FW'(PIPE_LAT - 1);

    typedef enum logic [1:0] {IDLE, ACTIVE, FLUSH, DONE} state_t;

    state_t              state_q, state_d;
    logic [10:0]         x_q, x_d;
    logic [10:0]         y_q, y_d;
    logic                vert_q, vert_d;
    logic [PIPE_LAT-1:0] dly_q, dly_d;
    logic [FW-1:0]       flush_q, flush_d;
    logic                accept;
    logic                win;

    assign accept = (state_q == ACTIVE) && iDVAL;
    assign win    = accept && (x_q >= 11'd2) && (y_q >= 11'd2);

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        vert_d  = vert_q;
        flush_d = flush_q;
        dly_d   = PIPE_LAT'({dly_q, win});

        // A frame start restarts from any state and wins over a coincident pixel.
        if (iFRAME_START) begin
            state_d = ACTIVE;
            x_d     = '0;
            y_d     = '0;
            vert_d  = iMODE;
            flush_d = '0;
            dly_d   = '0;
        end else begin
            case (state_q)
                ACTIVE: begin
                    if (iDVAL) begin
                        if (x_q == X_LAST) begin
                            x_d = '0;
                            if (y_q == Y_LAST) begin
                                y_d     = '0;
                                flush_d = '0;
                                state_d = FLUSH;
                            end else begin
                                y_d = y_q + 11'd1;
                            end
                        end else begin
                            x_d = x_q + 11'd1;
                        end
                    end
                end
                FLUSH: begin
                    if (flush_q == FLUSH_LAST) begin
                        state_d = DONE;
                    end else begin
                        flush_d = flush_q + FW'(1);
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            vert_q  <= 1'b1;
            flush_q <= '0;
            dly_q   <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            vert_q  <= vert_d;
            flush_q <= flush_d;
            dly_q   <= dly_d;
        end
    end

    assign oLB_CLKEN   = accept;
    assign oWIN_VALID  = win;
    assign oBORDER     = accept && !win;
    assign oDVAL       = dly_q[PIPE_LAT-1];
    assign oVERTICAL   = vert_q;
    assign oX          = x_q;
    assign oY          = y_q;
    assign oFRAME_DONE = (state_q == DONE);
    assign oBUSY       = (state_q != IDLE);

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Directed bench for conv_seq_ctrl on a 4x3 image with a two-cycle pipeline.
module tb_conv_seq_ctrl;

    logic        iCLK;
    logic        iRST;
    logic        iDVAL;
    logic        iFRAME_START;
    logic        iMODE;
    logic        oLB_CLKEN;
    logic        oVERTICAL;
    logic        oWIN_VALID;
    logic        oBORDER;
    logic        oDVAL;
    logic [10:0] oX;
    logic [10:0] oY;
    logic        oFRAME_DONE;
    logic        oBUSY;

    int tests    = 0;
    int failures = 0;
    int n_win, n_dval, n_done;

    conv_seq_ctrl #(.IMG_W(4), .IMG_H(3), .PIPE_LAT(2)) dut (
        .iCLK(iCLK), .iRST(iRST), .iDVAL(iDVAL), .iFRAME_START(iFRAME_START),
        .iMODE(iMODE), .oLB_CLKEN(oLB_CLKEN), .oVERTICAL(oVERTICAL),
        .oWIN_VALID(oWIN_VALID), .oBORDER(oBORDER), .oDVAL(oDVAL),
        .oX(oX), .oY(oY), .oFRAME_DONE(oFRAME_DONE), .oBUSY(oBUSY)
    );

    initial begin
        iCLK = 1'b0;
        forever #5 iCLK = ~iCLK;
    end

    // Inputs change 1 time unit after the edge; outputs are sampled mid-cycle.
    task automatic applyStimulus(input logic rst, input logic dval, input logic start, input logic mode);
        @(posedge iCLK);
        #1;
        iRST         = rst;
        iDVAL        = dval;
        iFRAME_START = start;
        iMODE        = mode;
        #4;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic checkAll(input string tag, input logic clken, input logic win, input logic border,
                            input logic dval, input int x, input int y, input logic vert,
                            input logic done, input logic busy);
        checkOutput({tag, ".clken"},  32'(oLB_CLKEN),   32'(clken));
        checkOutput({tag, ".win"},    32'(oWIN_VALID),  32'(win));
        checkOutput({tag, ".border"}, 32'(oBORDER),     32'(border));
        checkOutput({tag, ".dval"},   32'(oDVAL),       32'(dval));
        checkOutput({tag, ".x"},      32'(oX),          32'(x));
        checkOutput({tag, ".y"},      32'(oY),          32'(y));
        checkOutput({tag, ".vert"},   32'(oVERTICAL),   32'(vert));
        checkOutput({tag, ".done"},   32'(oFRAME_DONE), 32'(done));
        checkOutput({tag, ".busy"},   32'(oBUSY),       32'(busy));
    endtask

    initial begin
        iRST = 1'b1; iDVAL = 1'b0; iFRAME_START = 1'b0; iMODE = 1'b0;

        applyStimulus(1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        checkAll("reset", 0, 0, 0, 0, 0, 0, 1, 0, 0);

        // Frame 1: contiguous pixels, iMODE wiggled mid-frame must not leak into oVERTICAL.
        applyStimulus(0, 0, 1, 0);
        checkAll("f1.start", 0, 0, 0, 0, 0, 0, 1, 0, 0);
        for (int k = 1; k <= 12; k++) begin
            applyStimulus(0, 1, 0, 1);
            checkAll($sformatf("f1.px%0d", k), 1, k >= 11, k <= 10, 0, (k - 1) % 4, (k - 1) / 4, 0, 0, 1);
        end
        applyStimulus(0, 1, 0, 0);
        checkAll("f1.flush1", 0, 0, 0, 1, 0, 0, 0, 0, 1);
        applyStimulus(0, 1, 0, 0);
        checkAll("f1.flush2", 0, 0, 0, 1, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0);
        checkAll("f1.done", 0, 0, 0, 0, 0, 0, 0, 1, 1);
        applyStimulus(0, 1, 0, 0);
        checkAll("f1.idle", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0);
        checkAll("f1.idle2", 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Frame 2: one-on/one-off pixel stream.
        applyStimulus(0, 0, 1, 0);
        n_win = 0; n_dval = 0; n_done = 0;
        for (int i = 0; i < 32; i++) begin
            applyStimulus(0, (i < 24) && (i % 2 == 0), 0, 0);
            n_win  += int'(oWIN_VALID);
            n_dval += int'(oDVAL);
            n_done += int'(oFRAME_DONE);
            if ((i % 2 == 1) && (i < 24)) begin
                checkOutput($sformatf("f2.gap%0d.x", i), 32'(oX), 32'(((i + 1) / 2) % 4));
                checkOutput($sformatf("f2.gap%0d.y", i), 32'(oY), 32'((((i + 1) / 2) / 4) % 3));
            end
        end
        checkOutput("f2.win_count",  32'(n_win),  32'd2);
        checkOutput("f2.dval_count", 32'(n_dval), 32'd2);
        checkOutput("f2.done_count", 32'(n_done), 32'd1);
        checkOutput("f2.idle_busy",  32'(oBUSY),  32'd0);

        // Frame 3: restart with iMODE=1 on pixel 7.
        applyStimulus(0, 0, 1, 0);
        for (int k = 1; k <= 6; k++) applyStimulus(0, 1, 0, 0);
        checkOutput("f3.px6.x", 32'(oX), 32'd1);
        applyStimulus(0, 1, 1, 1);
        applyStimulus(0, 0, 0, 0);
        checkAll("f3.restart", 0, 0, 0, 0, 0, 0, 1, 0, 1);
        for (int k = 1; k <= 12; k++) begin
            applyStimulus(0, 1, 0, 0);
            checkAll($sformatf("f3.px%0d", k), 1, k >= 11, k <= 10, 0, (k - 1) % 4, (k - 1) / 4, 1, 0, 1);
        end
        applyStimulus(0, 0, 0, 0);
        checkOutput("f3.post1.done", 32'(oFRAME_DONE), 32'd0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("f3.post2.done", 32'(oFRAME_DONE), 32'd0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("f3.post3.done", 32'(oFRAME_DONE), 32'd1);
        applyStimulus(0, 0, 0, 0);
        checkOutput("f3.post4.busy", 32'(oBUSY), 32'd0);

        // Frame 4: restart coincides with the last pixel, so no FLUSH/DONE follows.
        applyStimulus(0, 0, 1, 0);
        for (int k = 1; k <= 11; k++) applyStimulus(0, 1, 0, 0);
        checkOutput("f4.px11.x", 32'(oX), 32'd2);
        applyStimulus(0, 1, 1, 0);
        n_done = 0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 0, 0, 0);
            n_done += int'(oFRAME_DONE);
            checkOutput($sformatf("f4.hold%0d.busy", i), 32'(oBUSY), 32'd1);
        end
        checkOutput("f4.x", 32'(oX), 32'd0);
        checkOutput("f4.y", 32'(oY), 32'd0);
        checkOutput("f4.done_count", 32'(n_done), 32'd0);

        // Mid-frame reset on pixel 8, then pixels with no frame start.
        for (int k = 1; k <= 7; k++) applyStimulus(0, 1, 0, 0);
        checkOutput("f5.px7.x", 32'(oX), 32'd2);
        checkOutput("f5.px7.y", 32'(oY), 32'd1);
        applyStimulus(1, 1, 0, 0);
        applyStimulus(0, 0, 0, 0);
        checkAll("f5.reset", 0, 0, 0, 0, 0, 0, 1, 0, 0);
        n_done = 0;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(0, 1, 0, 0);
            n_done += int'(oFRAME_DONE);
            checkAll($sformatf("f5.idle%0d", i), 0, 0, 0, 0, 0, 0, 1, 0, 0);
        end
        checkOutput("f5.done_count", 32'(n_done), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule

// File: doc/conv_seq_ctrl.md
CONV_SEQ_CTRL -- requirements
Module: conv_seq_ctrl

Interface
REQ-001 Parameter IMG_W, default 640, active pixels per line.
REQ-002 Parameter IMG_H, default 480, active lines per frame.
REQ-003 Parameter PIPE_LAT, default 2, cycles from pixel accept to convolution result (greyscale plus convolution stages).
REQ-004 iCLK  input  1  single clock; all state updates on the rising edge.
REQ-005 iRST  input  1  reset, synchronous, active-high.
REQ-006 iDVAL  input  1  incoming pixel valid, one pixel per asserted cycle.
REQ-007 iFRAME_START  input  1  single-cycle frame-start pulse.
REQ-008 iMODE  input  1  requested kernel direction (1 = vertical, 0 = horizontal).
REQ-009 oLB_CLKEN  output  1  line-buffer shift enable.
REQ-010 oVERTICAL  output  1  kernel direction latched for the current frame.
REQ-011 oWIN_VALID  output  1  the current pixel completes a full 3x3 window.
REQ-012 oBORDER  output  1  the current pixel is accepted but its window is incomplete.
REQ-013 oDVAL  output  1  convolution output valid, aligned to the pipeline result.
REQ-014 oX, oY  output  11 each  column and row counters of the current pixel.
REQ-015 oFRAME_DONE  output  1  single-cycle frame-complete pulse.
REQ-016 oBUSY  output  1  high in every state except IDLE.

Function
REQ-017 The FSM SHALL have four states: IDLE, ACTIVE, FLUSH and DONE.
REQ-018 In IDLE, iFRAME_START SHALL clear oX and oY, clear the oDVAL delay line, latch iMODE into oVERTICAL and move the FSM to ACTIVE.
REQ-019 In ACTIVE, oLB_CLKEN SHALL equal iDVAL; in every other state oLB_CLKEN SHALL be 0.
REQ-020 In ACTIVE, each iDVAL cycle SHALL increment oX; at oX = IMG_W-1, oX SHALL wrap to 0 and oY SHALL increment.
REQ-021 In ACTIVE, iDVAL low SHALL hold all counters.
REQ-022 oWIN_VALID SHALL equal ACTIVE & iDVAL & (oX >= 2) & (oY >= 2); the window is centred at (oX-1, oY-1).
REQ-023 oBORDER SHALL equal ACTIVE & iDVAL & !oWIN_VALID.
REQ-024 oDVAL SHALL equal oWIN_VALID delayed by exactly PIPE_LAT cycles through a shift register that runs in every state.
REQ-025 iDVAL with oX = IMG_W-1 and oY = IMG_H-1 SHALL move the FSM to FLUSH; the counters SHALL wrap to 0,0.
REQ-026 FLUSH SHALL last exactly PIPE_LAT cycles and then move the FSM to DONE.
REQ-027 DONE SHALL assert oFRAME_DONE for exactly one cycle and then return to IDLE.
REQ-028 Mid-frame restart: iFRAME_START in ACTIVE, FLUSH or DONE SHALL act as in IDLE and move the FSM to ACTIVE.
  - any pending oFRAME_DONE is suppressed.
  - if it coincides with a pixel, that pixel is not counted.
REQ-029 iFRAME_START coinciding with the last pixel SHALL take priority (restart; no FLUSH).
REQ-030 iDVAL outside ACTIVE SHALL be ignored: no counting, no oWIN_VALID, no oBORDER.
REQ-031 iMODE SHALL affect oVERTICAL only at a frame-start event.
REQ-032 Counter arithmetic SHALL be unsigned 11-bit; IMG_W and IMG_H SHALL be at most 2047.

Reset
REQ-033 iRST SHALL take priority over all other inputs and act in any state.
REQ-034 Under iRST:
  - the FSM returns to IDLE.
  - oX = 0, oY = 0 and the delay line is cleared.
  - oVERTICAL = 1.
  - oLB_CLKEN, oWIN_VALID, oBORDER, oDVAL, oFRAME_DONE and oBUSY are all 0 in the cycle after reset.
REQ-035 A reset asserted mid-frame SHALL discard the frame and SHALL NOT pulse oFRAME_DONE.

Verification
REQ-036 IMG_W=4, IMG_H=3, PIPE_LAT=2; start with iMODE=0, then 12 consecutive iDVAL -> expected response:
  - oBORDER on pixels 1-10.
  - oWIN_VALID on pixels 11-12.
  - oDVAL 2 cycles after each oWIN_VALID.
  - oFRAME_DONE 3 cycles after pixel 12.
  - oVERTICAL = 0.
REQ-037 Same frame with iDVAL gapped (1 on, 1 off) -> counters hold in gaps; expected: 2 oWIN_VALID, 2 oDVAL, exactly one oFRAME_DONE.
REQ-038 iFRAME_START with iMODE=1 at pixel 7 -> oX=0, oY=0 next cycle and oVERTICAL=1; no oFRAME_DONE until 12 further pixels.
REQ-039 iFRAME_START coinciding with pixel 12 -> FSM stays ACTIVE and no oFRAME_DONE pulse occurs.
REQ-040 iRST at pixel 8 -> next cycle all outputs 0, oBUSY=0; then 20 iDVAL cycles without a start -> oLB_CLKEN stays 0 and the counters stay 0.
REQ-041 iDVAL held high in IDLE and in FLUSH -> oLB_CLKEN=0 and the counters do not change.
